// File: rtl/clint_timer_if.sv
// ----------------------------------------------------------------------------
// clint_timer_if
//   Simple word bus between the core and the CLINT.
//   bus_sel   : request valid, sampled every rising clk edge
//   bus_we    : 1 = write, 0 = read
//   bus_addr  : byte offset within the CLINT region
//   bus_wdata : write data (full word)
//   bus_rdata : read data, valid while bus_ready=1, otherwise 0
//   bus_ready : one-cycle response strobe, the cycle after acceptance
//   bus_err   : qualifies bus_ready: unmapped or misaligned access
// ----------------------------------------------------------------------------
interface clint_timer_if;
    logic        bus_sel;
    logic        bus_we;
    logic [15:0] bus_addr;
    logic [31:0] bus_wdata;
    logic [31:0] bus_rdata;
    logic        bus_ready;
    logic        bus_err;

    modport master (
        output bus_sel, bus_we, bus_addr, bus_wdata,
        input  bus_rdata, bus_ready, bus_err
    );

    modport slave (
        input  bus_sel, bus_we, bus_addr, bus_wdata,
        output bus_rdata, bus_ready, bus_err
    );
endinterface

// File: rtl/clint_timer.sv
// ----------------------------------------------------------------------------
// clint_timer
//   Core-local interruptor: free-running 64-bit mtime, 64-bit mtimecmp and
//   the software-interrupt bit msip, all memory-mapped on the word bus.
//   Produces the machine pending word (MTIP = bit 7, MSIP = bit 3).
//   Ports:
//     clk       : core clock
//     reset_n   : asynchronous, active-low reset
//     bus       : clint_timer_if slave port (request / one-cycle response)
//     mip_out   : pending word to the CSR file, only bits 7 and 3 used
//     mtime_out : current mtime, for rdtime / debug
// ----------------------------------------------------------------------------
module clint_timer #(
    parameter int unsigned PRESCALE   = 1,
    parameter bit          BASE_CHECK = 1'b1
) (
    input  logic                clk,
    input  logic                reset_n,
    clint_timer_if.slave        bus,
    output logic [31:0]         mip_out,
    output logic [63:0]         mtime_out
);

    localparam logic [15:0] ADDR_MSIP     = 16'h0000;
    localparam logic [15:0] ADDR_CMP_LO   = 16'h4000;
    localparam logic [15:0] ADDR_CMP_HI   = 16'h4004;
    localparam logic [15:0] ADDR_TIME_LO  = 16'hBFF8;
    localparam logic [15:0] ADDR_TIME_HI  = 16'hBFFC;
    localparam logic [15:0] PS_LAST       = 16'(PRESCALE - 1);

    logic [63:0] mtime;
    logic [63:0] mtimecmp;
    logic        msip;
    logic [15:0] ps_cnt;
    logic        mtip_q;
    logic        msip_pend_q;
    logic [31:0] rdata_q;
    logic        ready_q;
    logic        err_q;

    logic [15:0] word_addr;
    logic        hit_msip, hit_cmp_lo, hit_cmp_hi, hit_time_lo, hit_time_hi;
    logic        aligned, mapped, acc_ok;
    logic        wr_ok, rd_ok;
    logic        tick;
    logic [31:0] rd_mux;

    always_comb begin
        word_addr   = {bus.bus_addr[15:2], 2'b00};
        hit_msip    = (word_addr == ADDR_MSIP);
        hit_cmp_lo  = (word_addr == ADDR_CMP_LO);
        hit_cmp_hi  = (word_addr == ADDR_CMP_HI);
        hit_time_lo = (word_addr == ADDR_TIME_LO);
        hit_time_hi = (word_addr == ADDR_TIME_HI);
        aligned     = !BASE_CHECK || (bus.bus_addr[1:0] == 2'b00);
        mapped      = hit_msip | hit_cmp_lo | hit_cmp_hi | hit_time_lo | hit_time_hi;
        acc_ok      = aligned & mapped;
        wr_ok       = bus.bus_sel & bus.bus_we & acc_ok;
        rd_ok       = bus.bus_sel & ~bus.bus_we & acc_ok;
        tick        = (ps_cnt == PS_LAST);

        rd_mux = '0;
        if (hit_msip)    rd_mux = {31'b0, msip};
        if (hit_cmp_lo)  rd_mux = mtimecmp[31:0];
        if (hit_cmp_hi)  rd_mux = mtimecmp[63:32];
        if (hit_time_lo) rd_mux = mtime[31:0];
        if (hit_time_hi) rd_mux = mtime[63:32];
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mtime       <= '0;
            mtimecmp    <= '1;
            msip        <= 1'b0;
            ps_cnt      <= '0;
            mtip_q      <= 1'b0;
            msip_pend_q <= 1'b0;
            rdata_q     <= '0;
            ready_q     <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            ps_cnt <= tick ? '0 : ps_cnt + 16'd1;

            // A bus write to either mtime half swallows that edge's tick;
            // the prescaler itself keeps running regardless.
            if (wr_ok && hit_time_lo)
                mtime <= {mtime[63:32], bus.bus_wdata};
            else if (wr_ok && hit_time_hi)
                mtime <= {bus.bus_wdata, mtime[31:0]};
            else if (tick)
                mtime <= mtime + 64'd1;

            if (wr_ok && hit_cmp_lo) mtimecmp[31:0]  <= bus.bus_wdata;
            if (wr_ok && hit_cmp_hi) mtimecmp[63:32] <= bus.bus_wdata;
            if (wr_ok && hit_msip)   msip            <= bus.bus_wdata[0];

            mtip_q      <= (mtime >= mtimecmp);
            msip_pend_q <= msip;

            ready_q <= bus.bus_sel;
            err_q   <= bus.bus_sel & ~acc_ok;
            rdata_q <= rd_ok ? rd_mux : '0;
        end
    end

    assign bus.bus_rdata = rdata_q;
    assign bus.bus_ready = ready_q;
    assign bus.bus_err   = err_q;
    assign mip_out       = {24'b0, mtip_q, 3'b0, msip_pend_q, 3'b0};
    assign mtime_out     = mtime;

endmodule
